// File: rtl/alu_exec.sv
// Execute/writeback stage of the 8-bit CPU datapath: reads two registers, runs one ALU op, writes back.
// Optional iterative shift-add multiplier for Op=111 is built only when ALU_MUL_EN is defined.
module alu_exec (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic [2:0] Op,
   input  logic [1:0] Rs1,
   input  logic [1:0] Rs2,
   input  logic [1:0] Rd,
   output logic [1:0] N1,
   output logic [1:0] N2,
   input  logic [7:0] Q1,
   input  logic [7:0] Q2,
   output logic [1:0] ND,
   output logic [7:0] DI,
   output logic       REG_WE,
   output logic       Busy,
   output logic       Done,
   output logic       ZF,
   output logic       CF
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
`endif

   state_t     state;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic [7:0] r;
   logic       pend_c;
   logic       wr_ok;

`ifdef ALU_MUL_EN
   logic [15:0] p;
   logic [15:0] mcand;
   logic [7:0]  mplier;
   logic [2:0]  count;
   logic [15:0] p_nxt;
`endif

   // Single-cycle ALU: result in [7:0], carry/borrow in [8].
   function automatic logic [8:0] alu_f(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
      logic [8:0] t;
      t = {1'b0, x};
      case (f)
         OP_ADD:  t = {1'b0, x} + {1'b0, y};
         OP_SUB:  t = {1'b0, x} - {1'b0, y};
         OP_AND:  t = {1'b0, x & y};
         OP_OR:   t = {1'b0, x | y};
         OP_XOR:  t = {1'b0, x ^ y};
         OP_SHL:  t = {x[7], x[6:0], 1'b0};
         OP_SHR:  t = {x[0], 1'b0, x[7:1]};
         default: t = {1'b0, x};
      endcase
      return t;
   endfunction

   assign N1 = Rs1;
   assign N2 = Rs2;
   assign DI = r;

`ifdef ALU_MUL_EN
   assign wr_ok = 1'b1;
   assign p_nxt = p + (mplier[0] ? mcand : 16'h0000);
`else
   // Without the multiplier an Op=111 request completes but leaves registers and flags alone.
   assign wr_ok = (op != OP_MUL);
`endif

   assign Busy   = (state != S_IDLE);
   assign Done   = (state == S_WB);
   assign REG_WE = (state == S_WB) && wr_ok;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state  <= S_IDLE;
         a      <= '0;
         b      <= '0;
         op     <= '0;
         r      <= '0;
         ND     <= '0;
         pend_c <= 1'b0;
         ZF     <= 1'b0;
         CF     <= 1'b0;
`ifdef ALU_MUL_EN
         p      <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  a  <= Q1;
                  b  <= Q2;
                  op <= Op;
                  ND <= Rd;
`ifdef ALU_MUL_EN
                  p      <= '0;
                  mcand  <= {8'h00, Q1};
                  mplier <= Q2;
                  count  <= '0;
                  state  <= (Op == OP_MUL) ? S_MUL : S_EXEC;
`else
                  state  <= S_EXEC;
`endif
               end
            end
            S_EXEC: begin
               if (wr_ok) begin
                  {pend_c, r} <= alu_f(op, a, b);
               end
               state <= S_WB;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
               p      <= p_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 3'd1;
               // Eighth partial product has just been added when count wraps.
               if (count == 3'd7) begin
                  r      <= p_nxt[7:0];
                  pend_c <= |p_nxt[15:8];
                  state  <= S_WB;
               end
            end
`endif
            S_WB: begin
               if (wr_ok) begin
                  ZF <= (r == 8'h00);
                  CF <= pend_c;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: a register file around the DUT, a reference model, and a monitor.
module tb_alu_exec;

`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       Start = 1'b0;
   logic [2:0] Op = '0;
   logic [1:0] Rs1 = '0, Rs2 = '0, Rd = '0;
   logic [1:0] N1, N2, ND;
   logic [7:0] Q1, Q2, DI;
   logic       REG_WE, Busy, Done, ZF, CF;

   alu_exec dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
      .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .N1(N1), .N2(N2),
      .Q1(Q1), .Q2(Q2), .ND(ND), .DI(DI), .REG_WE(REG_WE),
      .Busy(Busy), .Done(Done), .ZF(ZF), .CF(CF)
   );

   always #5 Clock = ~Clock;

   // Environment register file: written by the DUT, or by the bench for setup.
   logic [7:0] regs [4];
   logic       tb_we = 1'b0;
   logic [1:0] tb_wa = '0;
   logic [7:0] tb_wd = '0;
   always @(posedge Clock) begin
      if (REG_WE) regs[ND] <= DI;
      else if (tb_we) regs[tb_wa] <= tb_wd;
   end
   assign Q1 = regs[N1];
   assign Q2 = regs[N2];

   int errors = 0;
   int checks = 0;
   int we_cnt = 0;
   always @(posedge Clock) if (REG_WE) we_cnt <= we_cnt + 1;

   typedef struct packed {
      logic [1:0] nd;
      logic [7:0] di;
      logic       we;
      logic       zf;
      logic       cf;
   } exp_t;
   exp_t exq[$];

   logic [7:0] mregs [4];
   logic       mzf = 1'b0, mcf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference model: plain integer arithmetic on the model's register copy.
   task automatic push_exp(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d);
      int x, y, res, c;
      exp_t e;
      x = mregs[s1];
      y = mregs[s2];
      c = 0;
      case (op)
         3'd0: begin res = (x + y) % 256; c = (x + y > 255) ? 1 : 0; end
         3'd1: begin res = (x - y + 256) % 256; c = (x < y) ? 1 : 0; end
         3'd2: res = x & y;
         3'd3: res = x | y;
         3'd4: res = x ^ y;
         3'd5: begin res = (x * 2) % 256; c = (x >= 128) ? 1 : 0; end
         3'd6: begin res = x / 2; c = x % 2; end
         default: begin res = (x * y) % 256; c = (x * y >= 256) ? 1 : 0; end
      endcase
      e.nd = d;
      e.di = res[7:0];
      e.we = (op != 3'd7) || MUL_EN;
      if (e.we) begin
         mregs[d] = res[7:0];
         mzf = (res == 0);
         mcf = c[0];
      end
      e.zf = mzf;
      e.cf = mcf;
      exq.push_back(e);
   endtask

   task automatic setreg(input logic [1:0] idx, input logic [7:0] val);
      @(negedge Clock);
      tb_we = 1'b1; tb_wa = idx; tb_wd = val;
      mregs[idx] = val;
      @(posedge Clock); #1;
      tb_we = 1'b0;
   endtask

   // Issues one op at E0 and returns #1 after the edge where Done rises.
   task automatic run_op(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [1:0] d, input bit hold);
      int lat;
      @(negedge Clock);
      Op = op; Rs1 = s1; Rs2 = s2; Rd = d; Start = 1'b1;
      #1;
      chk("read_id1", N1, s1);
      chk("read_id2", N2, s2);
      push_exp(op, s1, s2, d);
      @(posedge Clock); #1;
      if (!hold) Start = 1'b0;
      lat = 0;
      while (!Done && lat < 20) begin
         chk("busy_during_op", Busy, 1);
         @(posedge Clock); #1;
         lat++;
      end
      chk("latency", lat, (op == 3'd7 && MUL_EN) ? 8 : 1);
   endtask

   task automatic idle_after;
      @(posedge Clock); #1;
      chk("busy_after_wb", Busy, 0);
   endtask

   // Monitor: pops an expectation whenever Done is presented.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clock);
         if (Reset === 1'b1 && REG_WE === 1'b1 && Done !== 1'b1) chk("we_without_done", Done, 1);
         if (Reset === 1'b1 && Done === 1'b1) begin
            if (exq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = exq.pop_front();
               chk("write_id", ND, e.nd);
               chk("write_en", REG_WE, e.we);
               if (e.we) chk("write_data", DI, e.di);
               @(posedge Clock); #1;
               chk("zero_flag", ZF, e.zf);
               chk("carry_flag", CF, e.cf);
            end
         end
      end
   end

   initial begin
      int w0;
      #12;
      chk("rst_we", REG_WE, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_zf", ZF, 0);
      chk("rst_cf", CF, 0);
      chk("rst_nd", ND, 0);
      chk("rst_di", DI, 0);
      @(negedge Clock);
      Reset = 1'b1;
      setreg(0, 8'h00); setreg(1, 8'h00); setreg(2, 8'h00); setreg(3, 8'h00);

      // ADD with carry out
      setreg(1, 8'hF0); setreg(2, 8'h20);
      run_op(3'd0, 2'd1, 2'd2, 2'd3, 1'b0); idle_after();
      chk("r3_after_add", regs[3], 8'h10);

      // SUB to zero, then SUB with borrow
      setreg(0, 8'h05);
      run_op(3'd1, 2'd0, 2'd0, 2'd0, 1'b0); idle_after();
      setreg(1, 8'h03); setreg(2, 8'h05);
      run_op(3'd1, 2'd1, 2'd2, 2'd3, 1'b0); idle_after();

      // MUL vectors (no write when the multiplier is absent)
      setreg(1, 8'h0D); setreg(2, 8'h0B);
      run_op(3'd7, 2'd1, 2'd2, 2'd0, 1'b0); idle_after();
      setreg(1, 8'h20); setreg(2, 8'h10);
      run_op(3'd7, 2'd1, 2'd2, 2'd3, 1'b0); idle_after();

      // Start held through a whole MUL: one write, next op only after WB
      setreg(1, 8'h07); setreg(2, 8'h09);
      w0 = we_cnt;
      run_op(3'd7, 2'd1, 2'd2, 2'd0, 1'b1);
      @(posedge Clock); #1;
      chk("start_ignored_in_wb", Busy, 0);
      Op = 3'd0; Rs1 = 2'd1; Rs2 = 2'd2; Rd = 2'd3;
      push_exp(3'd0, 2'd1, 2'd2, 2'd3);
      @(posedge Clock); #1;
      chk("accept_after_wb", Busy, 1);
      Start = 1'b0;
      for (int i = 0; i < 20 && !Done; i++) begin @(posedge Clock); #1; end
      idle_after();
      chk("write_count", we_cnt - w0, MUL_EN ? 2 : 1);

      // Reset during an operation aborts without writeback
      setreg(1, 8'hFF); setreg(2, 8'hFF);
      @(negedge Clock);
      Op = MUL_EN ? 3'd7 : 3'd0; Rs1 = 2'd1; Rs2 = 2'd2; Rd = 2'd0; Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (MUL_EN ? 3 : 0) @(posedge Clock);
      #3;
      Reset = 1'b0;
      mzf = 1'b0; mcf = 1'b0;
      #1;
      chk("abort_we", REG_WE, 0);
      chk("abort_busy", Busy, 0);
      chk("abort_zf", ZF, 0);
      chk("abort_cf", CF, 0);
      chk("abort_di", DI, 0);
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b1;
      chk("abort_target", regs[0], mregs[0]);

      // Randomized traffic
      for (int k = 0; k < 40; k++) begin
         setreg(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         run_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'b0);
         idle_after();
      end

      repeat (3) @(posedge Clock);
      chk("queue_empty", exq.size(), 0);
      for (int i = 0; i < 4; i++) chk("regfile_final", regs[i], mregs[i]);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute/writeback stage of the 8-bit CPU datapath.
- Sits between the 4x8 register file's read ports and its write port.
- On Start it drives the two source register ids and captures the operands. It then computes one ALU operation, single-cycle or iterative 8-cycle multiply.
- It writes the result back with a one-cycle write-enable pulse and updates the Z/C flags.

Parameters:
- none (datapath fixed at 8 bits, 4 registers)

Ports:
- Clock   in   1  system clock, rising edge
- Reset   in   1  asynchronous, active-low reset
- Start   in   1  request; sampled only in IDLE
- Op      in   3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1, 111 MUL
- Rs1     in   2  source-1 register id
- Rs2     in   2  source-2 register id
- Rd      in   2  destination register id
- N1      out  2  register file read id 1; equals Rs1 combinationally
- N2      out  2  register file read id 2; equals Rs2 combinationally
- Q1      in   8  register file read data 1
- Q2      in   8  register file read data 2
- ND      out  2  write id; latched Rd
- DI      out  8  write data; result register R
- REG_WE  out  1  write enable; high exactly one cycle per accepted op
- Busy    out  1  high whenever state != IDLE
- Done    out  1  high in the same cycle as REG_WE
- ZF      out  1  zero flag, registered
- CF      out  1  carry flag, registered

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE.
  - REG_WE=0, Done=0, Busy=0, ZF=0, CF=0.
  - ND=0, DI=0; internal A, B, R, P, count cleared.
  - Reset mid-operation aborts it immediately with no writeback; REG_WE drops asynchronously.
- States: IDLE, EXEC, MUL, WB.
- REG_WE, Done and Busy are decoded from the state register only.
- IDLE:
  - At an edge E0 with Start=1: A<=Q1, B<=Q2, op<=Op, ND<=Rd.
  - Next state is MUL if Op=111, else EXEC.
  - Start=0: remain in IDLE.
- EXEC (one cycle): at edge E1, R<=f(A,B) and the pending flags are computed; next state WB.
  - ADD: R = A+B mod 256; C = carry out of bit 7.
  - SUB: R = A-B mod 256; C = borrow (A<B unsigned).
  - AND / OR / XOR: C = 0.
  - SHL1: R = {A[6:0],0}; C = A[7].
  - SHR1: R = {0,A[7:1]}; C = A[0].
- MUL (Op=111):
  - Uses a 16-bit accumulator P (cleared at E0), a 16-bit shifted multiplicand (=A) and a multiplier shift register (=B).
  - Each of edges E1..E8: if multiplier[0], P += multiplicand; multiplicand<<=1; multiplier>>=1; 3-bit count increments.
  - At E8 (count wraps 7->0): R<=P[7:0]; C = (P[15:8] != 0); next state WB.
- WB (one cycle):
  - REG_WE=1, Done=1, ND=latched Rd, DI=R.
  - At the closing edge, ZF<=(R==0) and CF<=pending C; next state IDLE.
  - The register file captures DI at that same edge.
- Latency, Start edge to write edge:
  - Simple ops: REG_WE high between E1 and E2; data written at E2.
  - MUL: REG_WE high between E8 and E9; data written at E9.
- Start handling while busy:
  - Start is ignored while Busy=1, including the WB cycle; there is no queueing.
  - Earliest next accept is the edge after WB.
- Operands are captured at E0, so Rd equal to Rs1 or Rs2 is safe.
- Register file contents changing during EXEC/MUL do not affect the result.
- ZF/CF hold their values between operations and change only at the WB edge.
- DI holds the last R value while idle.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL state and multiplier logic present; Op=111 behaves as above.
- Undefined:
  - No MUL state or accumulator hardware.
  - Op=111 goes IDLE->EXEC->WB with Done=1 in WB but REG_WE held 0 (no register write).
  - ZF/CF unchanged; latency identical to simple ops.

Test Plan:
- ADD: R1=0xF0, R2=0x20, Op=000, Rd=3 -> REG_WE pulse at E1..E2, ND=3, DI=0x10, CF=1, ZF=0; R3 reads 0x10 afterwards.
- SUB: Rs1=Rs2=R0=0x05, Op=001, Rd=0 -> DI=0x00, ZF=1, CF=0; then 0x03-0x05 -> DI=0xFE, CF=1.
- MUL (ALU_MUL_EN): 0x0D*0x0B -> DI=0x8F, CF=0, Busy high 9 cycles, write at E9; 0x20*0x10 -> DI=0x00, ZF=1, CF=1.
- Busy handling: assert Start continuously during a MUL -> exactly one write; new op accepted only at the edge after WB.
- Reset mid-MUL (Reset low at E4) -> REG_WE never asserts, Busy=0, ZF=CF=0, target register unchanged.
- ALU_MUL_EN undefined: Op=111 -> Done pulse at E1..E2, REG_WE stays 0, flags unchanged.
